// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the two-requester register-file arbiter.
package regfile_arb_pkg;

    localparam int unsigned AW_DEF = 3;
    localparam int unsigned DW_DEF = 4;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_arbiter_if.sv
// Requester-side handshake bundle: both requesters' command and response signals.
interface regfile_arbiter_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4
);
    logic          req_a;
    logic          req_b;
    logic          we_a;
    logic          we_b;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_a;
    logic [DW-1:0] wdata_b;
    logic          ack_a;
    logic          ack_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  ack_a, ack_b, rdata_a, rdata_b
    );

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output ack_a, ack_b, rdata_a, rdata_b
    );
endinterface

// File: rtl/regfile_arbiter_rr.sv
// Two-way round-robin grant: rr = 0 prefers A, rr = 1 prefers B.
module rr_arbiter2
    import regfile_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       rr_next
);

    // Grant the sole requester, or the preferred one on contention; point rr at the loser.
    always_comb begin
        gnt     = req;
        rr_next = rr;
        if (req == 2'b11) begin
            gnt = rr ? 2'b10 : 2'b01;
        end
        if (en && (|req)) begin
            rr_next = gnt[ID_A];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin controller driving one register-file access at a time for two requesters.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_arbiter_if.slave    req_if,
    output logic [AW-1:0]       rf_addr,
    output logic [DW-1:0]       rf_wdata,
    output logic                rf_read,
    output logic                rf_write,
    input  logic [DW-1:0]       rf_rdata,
    output logic                busy
);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic          cmd_we_q, cmd_we_d;
    logic          cmd_id_q, cmd_id_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          rf_read_q, rf_read_d;
    logic          rf_write_q, rf_write_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          busy_q, busy_d;

    logic [1:0]    gnt;
    logic          rr_next;

    rr_arbiter2 u_rr (
        .req     ({req_if.req_b, req_if.req_a}),
        .rr      (rr_q),
        .en      (state_q == IDLE),
        .gnt     (gnt),
        .rr_next (rr_next)
    );

    // Next-state and output decode; rf_addr/rf_wdata flops double as the command latch.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_next;
        cmd_we_d   = cmd_we_q;
        cmd_id_d   = cmd_id_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        rf_read_d  = 1'b0;
        rf_write_d = 1'b0;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d = ISSUE;
                    if (gnt[ID_B]) begin
                        cmd_id_d   = ID_B;
                        cmd_we_d   = req_if.we_b;
                        rf_addr_d  = req_if.addr_b;
                        rf_wdata_d = req_if.wdata_b;
                    end else begin
                        cmd_id_d   = ID_A;
                        cmd_we_d   = req_if.we_a;
                        rf_addr_d  = req_if.addr_a;
                        rf_wdata_d = req_if.wdata_a;
                    end
                    rf_read_d  = !cmd_we_d;
                    rf_write_d = cmd_we_d;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = ACK;
                ack_a_d = (cmd_id_q == ID_A);
                ack_b_d = (cmd_id_q == ID_B);
                if (!cmd_we_q) begin
                    if (cmd_id_q == ID_A) rdata_a_d = rf_rdata;
                    else                  rdata_b_d = rf_rdata;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_id_q   <= ID_A;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_read_q  <= 1'b0;
            rf_write_q <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cmd_we_q   <= cmd_we_d;
            cmd_id_q   <= cmd_id_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_read_q  <= rf_read_d;
            rf_write_q <= rf_write_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_addr        = rf_addr_q;
    assign rf_wdata       = rf_wdata_q;
    assign rf_read        = rf_read_q;
    assign rf_write       = rf_write_q;
    assign busy           = busy_q;
    assign req_if.ack_a   = ack_a_q;
    assign req_if.ack_b   = ack_b_q;
    assign req_if.rdata_a = rdata_a_q;
    assign req_if.rdata_b = rdata_b_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x4 register file.
module tb_regfile_arbiter;
    import regfile_arb_pkg::*;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata = '0;
    logic          rf_read;
    logic          rf_write;
    logic          busy;

    regfile_arbiter_if #(.AW(AW), .DW(DW)) rq ();

    regfile_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (rq),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .rf_read  (rf_read),
        .rf_write (rf_write),
        .rf_rdata (rf_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Register file: registered read, not reset.
    logic [DW-1:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (rf_write) mem[rf_addr] <= rf_wdata;
        if (rf_read)  rf_rdata     <= mem[rf_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", {31'b0, rf_read & rf_write}, 32'd0);
            chk("ack_excl", {31'b0, rq.ack_a & rq.ack_b}, 32'd0);
        end
    end

    int ack_seq[$];

    task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        rq.req_a = 1'b1; rq.we_a = we; rq.addr_a = addr; rq.wdata_a = wd;
    endtask

    task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        rq.req_b = 1'b1; rq.we_b = we; rq.addr_b = addr; rq.wdata_b = wd;
    endtask

    // Count edges from the request until n_acks acks; report first ack cycle per requester.
    task automatic run(input int n_acks, input bit hold, output int cyc_a, output int cyc_b);
        int got = 0;
        cyc_a = 0;
        cyc_b = 0;
        for (int c = 1; c <= n_acks * 4 + 4 && got < n_acks; c++) begin
            @(posedge clk); #1;
            if (rq.ack_a) begin
                ack_seq.push_back(0); got++;
                if (cyc_a == 0) cyc_a = c;
                if (!hold) rq.req_a = 1'b0;
            end
            if (rq.ack_b) begin
                ack_seq.push_back(1); got++;
                if (cyc_b == 0) cyc_b = c;
                if (!hold) rq.req_b = 1'b0;
            end
        end
        if (hold) begin
            rq.req_a = 1'b0;
            rq.req_b = 1'b0;
        end
        chk("ack_count", got, n_acks);
    endtask

    // Step past the ACK cycle into IDLE.
    task automatic settle(input string tag);
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack_a"},   {31'b0, rq.ack_a}, 32'd0);
        chk({tag, "_ack_b"},   {31'b0, rq.ack_b}, 32'd0);
        chk({tag, "_rdata_a"}, {28'b0, rq.rdata_a}, 32'd0);
        chk({tag, "_rdata_b"}, {28'b0, rq.rdata_b}, 32'd0);
        chk({tag, "_rf_read"}, {31'b0, rf_read}, 32'd0);
        chk({tag, "_rf_write"},{31'b0, rf_write}, 32'd0);
        chk({tag, "_rf_addr"}, {29'b0, rf_addr}, 32'd0);
        chk({tag, "_rf_wdata"},{28'b0, rf_wdata}, 32'd0);
        chk({tag, "_busy"},    {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ca, cb;
        rq.req_a = 1'b0; rq.req_b = 1'b0; rq.we_a = 1'b0; rq.we_b = 1'b0;
        rq.addr_a = '0; rq.addr_b = '0; rq.wdata_a = '0; rq.wdata_b = '0;

        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        // 1: A writes 5 <- A, then reads it back.
        @(negedge clk); set_a(1'b1, 3'd5, 4'hA);
        run(1, 1'b0, ca, cb);
        chk("t1_wr_lat", ca, 3);
        settle("t1a");
        chk("t1_addr_hold", {29'b0, rf_addr}, 32'd5);
        @(negedge clk); set_a(1'b0, 3'd5, 4'h0);
        run(1, 1'b0, ca, cb);
        chk("t1_rd_lat", ca, 3);
        chk("t1_rdata_a", {28'b0, rq.rdata_a}, 32'hA);
        chk("t1_rdata_b", {28'b0, rq.rdata_b}, 32'h0);
        settle("t1b");

        // 2: simultaneous first request after reset -> A first, B four cycles later.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); check_reset("t2_rst"); rst_n = 1'b1;
        @(negedge clk); set_a(1'b0, 3'd5, 4'h0); set_b(1'b1, 3'd1, 4'h7);
        ack_seq.delete();
        run(2, 1'b0, ca, cb);
        chk("t2_ack_a_cyc", ca, 3);
        chk("t2_ack_b_cyc", cb, 7);
        chk("t2_rdata_a", {28'b0, rq.rdata_a}, 32'hA);
        settle("t2");

        // 3: both hold req for 8 accesses -> strict A,B alternation.
        @(negedge clk); set_a(1'b1, 3'd3, 4'h6); set_b(1'b0, 3'd3, 4'h0);
        ack_seq.delete();
        run(8, 1'b1, ca, cb);
        for (int i = 0; i < ack_seq.size(); i++)
            chk($sformatf("t3_order%0d", i), ack_seq[i], i % 2);
        chk("t3_rdata_b", {28'b0, rq.rdata_b}, 32'h6);
        settle("t3");

        // 4: A-only read moves rr to B; then B write and A read of addr 2 collide.
        @(negedge clk); set_a(1'b0, 3'd5, 4'h0);
        run(1, 1'b0, ca, cb);
        settle("t4a");
        @(negedge clk); set_b(1'b1, 3'd2, 4'h3); set_a(1'b0, 3'd2, 4'h0);
        run(2, 1'b0, ca, cb);
        chk("t4_ack_b_cyc", cb, 3);
        chk("t4_ack_a_cyc", ca, 7);
        chk("t4_rdata_a", {28'b0, rq.rdata_a}, 32'h3);
        settle("t4b");

        // 5: reset during WAIT of a read drops it; a reissued read completes.
        @(negedge clk); set_a(1'b0, 3'd5, 4'h0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0; rq.req_a = 1'b0;
        #1 check_reset("t5_rst");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("t5_no_ack", {31'b0, rq.ack_a}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); set_a(1'b0, 3'd5, 4'h0);
        run(1, 1'b0, ca, cb);
        chk("t5_lat", ca, 3);
        chk("t5_rdata_a", {28'b0, rq.rdata_a}, 32'hA);
        settle("t5");

        // 6: A drops req during ISSUE; access still completes.
        @(negedge clk); set_a(1'b1, 3'd6, 4'h9);
        @(posedge clk); #1;
        chk("t6_issue_wr", {31'b0, rf_write}, 32'd1);
        chk("t6_issue_addr", {29'b0, rf_addr}, 32'd6);
        rq.req_a = 1'b0;
        run(1, 1'b0, ca, cb);
        chk("t6_ack_cyc", ca + 1, 3);
        settle("t6a");
        @(posedge clk); #1;
        chk("t6_stay_idle", {31'b0, busy}, 32'd0);
        chk("t6_no_ack", {31'b0, rq.ack_a}, 32'd0);
        @(negedge clk); set_a(1'b0, 3'd6, 4'h0);
        run(1, 1'b0, ca, cb);
        chk("t6_rdata_a", {28'b0, rq.rdata_a}, 32'h9);
        settle("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
